// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the single physical-memory port between the I-cache and D-cache.
// One client is granted per transaction; its request passes straight through to memory
// and the memory response is routed straight back. A dead RELEASE cycle follows every
// completed transaction so memory always sees the strobes low between grants.
// Optional build macro: PMEM_ARBITER_ROUND_ROBIN_EN (alternate grants on ties instead of
// fixed D-over-I priority).
module pmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    input  logic                  i_pmem_read,
    input  logic                  i_pmem_write,
    input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e state_q;
    state_e state_d;

    logic req_i;
    logic req_d;

    assign req_i = i_pmem_read | i_pmem_write;
    assign req_d = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARBITER_ROUND_ROBIN_EN
    // Client of the last completed transaction; aborts leave it untouched.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic last_grant_q;
    logic last_grant_d;
`endif

    // Next-state selection: arbitration in IDLE, completion/abort tracking while serving.
    always_comb begin
        state_d = state_q;
`ifdef PMEM_ARBITER_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef PMEM_ARBITER_ROUND_ROBIN_EN
                if (req_d && req_i) begin
                    state_d = (last_grant_q == GRANT_I) ? SERVE_D : SERVE_I;
                end else if (req_d) begin
                    state_d = SERVE_D;
                end else if (req_i) begin
                    state_d = SERVE_I;
                end
`else
                if (req_d) begin
                    state_d = SERVE_D;
                end else if (req_i) begin
                    state_d = SERVE_I;
                end
`endif
            end
            SERVE_I: begin
                if (mem_resp) begin
                    state_d = RELEASE;
`ifdef PMEM_ARBITER_ROUND_ROBIN_EN
                    last_grant_d = GRANT_I;
`endif
                end else if (!req_i) begin
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    state_d = RELEASE;
`ifdef PMEM_ARBITER_ROUND_ROBIN_EN
                    last_grant_d = GRANT_D;
`endif
                end else if (!req_d) begin
                    state_d = IDLE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any in-flight grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
`ifdef PMEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q <= GRANT_I;
`endif
        end else begin
            state_q <= state_d;
`ifdef PMEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Port muxing: granted client passes through, everything else is held at zero.
    always_comb begin
        mem_address  = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_wdata    = '0;
        i_pmem_rdata = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        case (state_q)
            SERVE_I: begin
                mem_address  = i_pmem_address;
                mem_wdata    = i_pmem_wdata;
                mem_write    = i_pmem_write;
                mem_read     = i_pmem_read & ~i_pmem_write;
                i_pmem_rdata = mem_rdata;
                i_pmem_resp  = mem_resp;
            end
            SERVE_D: begin
                mem_address  = d_pmem_address;
                mem_wdata    = d_pmem_wdata;
                mem_write    = d_pmem_write;
                mem_read     = d_pmem_read & ~d_pmem_write;
                d_pmem_rdata = mem_rdata;
                d_pmem_resp  = mem_resp;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed vector bench for pmem_arbiter: one record per clock cycle holding the
// inputs for that cycle and the outputs expected while they are applied.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  i_pmem_address;
    logic         i_pmem_read;
    logic         i_pmem_write;
    logic [127:0] i_pmem_wdata;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic [15:0]  d_pmem_address;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pmem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .i_pmem_address (i_pmem_address),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_write   (i_pmem_write),
        .i_pmem_wdata   (i_pmem_wdata),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_address (d_pmem_address),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    typedef struct {
        string       nm;
        logic        rst;
        logic        ir;
        logic        iw;
        logic [15:0] ia;
        logic [31:0] iwd;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [31:0] dwd;
        logic        mr;
        logic [31:0] mrd;
        logic [15:0] ema;
        logic        erd;
        logic        ewr;
        logic [31:0] ewd;
        logic        eir;
        logic [31:0] eird;
        logic        edr;
        logic [31:0] edrd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic rst,
                       input logic ir, input logic iw, input logic [15:0] ia, input logic [31:0] iwd,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [31:0] dwd,
                       input logic mr, input logic [31:0] mrd,
                       input logic [15:0] ema, input logic erd, input logic ewr, input logic [31:0] ewd,
                       input logic eir, input logic [31:0] eird, input logic edr, input logic [31:0] edrd);
        vec_t v;
        v.nm = nm; v.rst = rst;
        v.ir = ir; v.iw = iw; v.ia = ia; v.iwd = iwd;
        v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.mr = mr; v.mrd = mrd;
        v.ema = ema; v.erd = erd; v.ewr = ewr; v.ewd = ewd;
        v.eir = eir; v.eird = eird; v.edr = edr; v.edrd = edrd;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input string f, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, exp);
        end
    endtask

    initial begin
        //  name           rst  ir iw ia       iwd       dr dw da       dwd  mr mrd           ema      rd wr wd        ir ird       dr drd
        add("reset",        1,  0, 0, 16'h0,   0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("idle",         0,  0, 0, 16'h0,   0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("d_req",        0,  0, 0, 16'h0,   0,        1, 0, 16'h1230,0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("d_pass",       0,  0, 0, 16'h0,   0,        1, 0, 16'h1230,0,   0, 0,            16'h1230,1, 0, 0,        0, 0,        0, 0);
        add("d_resp",       0,  0, 0, 16'h0,   0,        1, 0, 16'h1230,0,   1, 32'hDEADBEEF, 16'h1230,1, 0, 0,        0, 0,        1, 32'hDEADBEEF);
        add("d_release",    0,  0, 0, 16'h0,   0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("d_idle",       0,  0, 0, 16'h0,   0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("rst2",         1,  0, 0, 16'h0,   0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("tie_req",      0,  1, 0, 16'h0040,0,        0, 1, 16'h8000,1,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("tie_d",        0,  1, 0, 16'h0040,0,        0, 1, 16'h8000,1,   0, 0,            16'h8000,0, 1, 1,        0, 0,        0, 0);
        add("tie_d_resp",   0,  1, 0, 16'h0040,0,        0, 1, 16'h8000,1,   1, 5,            16'h8000,0, 1, 1,        0, 0,        1, 5);
        add("tie_rel",      0,  1, 0, 16'h0040,0,        0, 1, 16'h8000,1,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("tie2_idle",    0,  1, 0, 16'h0040,0,        0, 1, 16'h8000,1,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
`ifdef PMEM_ARBITER_ROUND_ROBIN_EN
        add("tie2_grant",   0,  1, 0, 16'h0040,0,        0, 1, 16'h8000,1,   1, 7,            16'h0040,1, 0, 0,        1, 7,        0, 0);
`else
        add("tie2_grant",   0,  1, 0, 16'h0040,0,        0, 1, 16'h8000,1,   1, 7,            16'h8000,0, 1, 1,        0, 0,        1, 7);
`endif
        add("tie2_rel",     0,  1, 0, 16'h0040,0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("tie2_idle2",   0,  1, 0, 16'h0040,0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("i_pass",       0,  1, 0, 16'h0040,0,        0, 0, 16'h0,   0,   0, 0,            16'h0040,1, 0, 0,        0, 0,        0, 0);
        add("i_resp",       0,  1, 0, 16'h0040,0,        0, 0, 16'h0,   0,   1, 32'hAAAA,     16'h0040,1, 0, 0,        1, 32'hAAAA, 0, 0);
        add("i_rel",        0,  0, 0, 16'h0,   0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("i3_req",       0,  1, 0, 16'h0100,0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("i3_w1",        0,  1, 0, 16'h0100,0,        0, 0, 16'h0,   0,   0, 0,            16'h0100,1, 0, 0,        0, 0,        0, 0);
        add("i3_dreq",      0,  1, 0, 16'h0100,0,        1, 0, 16'h0200,0,   0, 32'h1234,     16'h0100,1, 0, 0,        0, 32'h1234, 0, 0);
        add("i3_w3",        0,  1, 0, 16'h0100,0,        1, 0, 16'h0200,0,   0, 0,            16'h0100,1, 0, 0,        0, 0,        0, 0);
        add("i3_w4",        0,  1, 0, 16'h0100,0,        1, 0, 16'h0200,0,   0, 0,            16'h0100,1, 0, 0,        0, 0,        0, 0);
        add("i3_resp",      0,  1, 0, 16'h0100,0,        1, 0, 16'h0200,0,   1, 32'hBEEF,     16'h0100,1, 0, 0,        1, 32'hBEEF, 0, 0);
        add("i3_rel",       0,  0, 0, 16'h0,   0,        1, 0, 16'h0200,0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("d3_idle",      0,  0, 0, 16'h0,   0,        1, 0, 16'h0200,0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("d3_grant",     0,  0, 0, 16'h0,   0,        1, 0, 16'h0200,0,   0, 0,            16'h0200,1, 0, 0,        0, 0,        0, 0);
        add("d_abort",      0,  0, 0, 16'h0,   0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("abort_idle",   0,  1, 0, 16'h0300,0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("i4_grant",     0,  1, 0, 16'h0300,0,        0, 0, 16'h0,   0,   0, 0,            16'h0300,1, 0, 0,        0, 0,        0, 0);
        add("rst_serve",    1,  1, 0, 16'h0300,0,        1, 0, 16'h0400,0,   0, 0,            16'h0300,1, 0, 0,        0, 0,        0, 0);
        add("after_rst",    0,  1, 0, 16'h0300,0,        1, 0, 16'h0400,0,   1, 32'h99,       16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("d5_grant",     0,  1, 0, 16'h0300,0,        1, 0, 16'h0400,0,   0, 0,            16'h0400,1, 0, 0,        0, 0,        0, 0);
        add("d5_resp",      0,  1, 0, 16'h0300,0,        1, 0, 16'h0400,0,   1, 32'h55,       16'h0400,1, 0, 0,        0, 0,        1, 32'h55);
        add("d5_rel",       0,  1, 1, 16'h0500,32'hF00D, 0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("d5_idle",      0,  1, 1, 16'h0500,32'hF00D, 0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);
        add("i_both",       0,  1, 1, 16'h0500,32'hF00D, 0, 0, 16'h0,   0,   0, 0,            16'h0500,0, 1, 32'hF00D, 0, 0,        0, 0);
        add("i_both_resp",  0,  1, 1, 16'h0500,32'hF00D, 0, 0, 16'h0,   0,   1, 0,            16'h0500,0, 1, 32'hF00D, 1, 0,        0, 0);
        add("i_both_rel",   0,  0, 0, 16'h0,   0,        0, 0, 16'h0,   0,   0, 0,            16'h0,   0, 0, 0,        0, 0,        0, 0);

        // Bring the design into a known state before the vector table starts.
        reset = 1'b1;
        i_pmem_address = '0; i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_pmem_wdata = '0;
        d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vq[k]) begin
            reset          = vq[k].rst;
            i_pmem_read    = vq[k].ir;
            i_pmem_write   = vq[k].iw;
            i_pmem_address = vq[k].ia;
            i_pmem_wdata   = 128'(vq[k].iwd);
            d_pmem_read    = vq[k].dr;
            d_pmem_write   = vq[k].dw;
            d_pmem_address = vq[k].da;
            d_pmem_wdata   = 128'(vq[k].dwd);
            mem_resp       = vq[k].mr;
            mem_rdata      = 128'(vq[k].mrd);
            @(negedge clk);
            chk(vq[k].nm, "mem_address",  128'(mem_address),  128'(vq[k].ema));
            chk(vq[k].nm, "mem_read",     128'(mem_read),     128'(vq[k].erd));
            chk(vq[k].nm, "mem_write",    128'(mem_write),    128'(vq[k].ewr));
            chk(vq[k].nm, "mem_wdata",    mem_wdata,          128'(vq[k].ewd));
            chk(vq[k].nm, "i_pmem_resp",  128'(i_pmem_resp),  128'(vq[k].eir));
            chk(vq[k].nm, "i_pmem_rdata", i_pmem_rdata,       128'(vq[k].eird));
            chk(vq[k].nm, "d_pmem_resp",  128'(d_pmem_resp),  128'(vq[k].edr));
            chk(vq[k].nm, "d_pmem_rdata", d_pmem_rdata,       128'(vq[k].edrd));
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Arbitrates between the instruction cache and the data cache for the single physical-memory port; sits directly downstream of both cache instances.
- Each cache-side port mirrors a cache's pmem interface: 16-bit address, 128-bit line data, read/write strobes, resp.
- Grants one client per transaction, passes that transaction through to memory, routes the response back, then releases the port.

Parameters:
- ADDR_WIDTH, 16, physical address width (lc3b_word).
- LINE_WIDTH, 128, cache line width (lc3b_chunk).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- i_pmem_address  input  ADDR_WIDTH  I-cache line address
- i_pmem_read  input  1  I-cache line read request
- i_pmem_write  input  1  I-cache line write request
- i_pmem_wdata  input  LINE_WIDTH  I-cache write line
- i_pmem_rdata  output  LINE_WIDTH  line returned to I-cache
- i_pmem_resp  output  1  I-cache transaction complete
- d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata, d_pmem_rdata, d_pmem_resp: same as the i_ set, for the D-cache
- mem_address  output  ADDR_WIDTH  to physical memory
- mem_read  output  1  to physical memory
- mem_write  output  1  to physical memory
- mem_wdata  output  LINE_WIDTH  to physical memory
- mem_rdata  input  LINE_WIDTH  from physical memory
- mem_resp  input  1  from physical memory

Behaviour:
- Clocking and reset: single clock, clk. reset is synchronous and active-high.
- State register: IDLE, SERVE_I, SERVE_D, RELEASE. Reset forces IDLE, including when a transaction is in flight. The in-flight memory request drops on the cycle after reset is sampled.
- Client request definition: req_x = x_pmem_read | x_pmem_write.

IDLE:
- Memory outputs are all zero and both resp outputs are 0.
- If req_d: go to SERVE_D. Else if req_i: go to SERVE_I. Else stay.
- This is fixed priority: D over I.

SERVE_x:
- Combinational pass-through from the granted client: x address, x wdata and x write go to mem_*.
- mem_read = x_read & ~x_write; write wins if a client illegally asserts both.
- mem_rdata goes to x_pmem_rdata and mem_resp goes to x_pmem_resp in the same cycle (zero added latency on response).
- On mem_resp: go to RELEASE.
- If the granted client drops req before mem_resp (abort): go to IDLE. mem_read and mem_write follow the client and are already 0 that cycle.
- The non-granted client sees rdata = 0 and resp = 0, and its request is held pending.

RELEASE:
- One dead cycle: memory outputs are zero and both resps are 0. This guarantees memory sees the strobe low between back-to-back transactions.
- Always go to IDLE.

Latency and timing:
- A request arriving in IDLE appears on mem_* one cycle later.
- Minimum turnaround between successive grants is 2 cycles after mem_resp (RELEASE, IDLE).
- Simultaneous req_i and req_d in IDLE: D is granted and I waits. I is granted in the next IDLE in which req_d is low.

Reset values:
- All outputs are 0: mem_address, mem_wdata, mem_read, mem_write, both rdata, both resp.
- Outputs are combinational from state, so they read 0 in the first cycle after reset.

Grant stability:
- Once granted, a client keeps the port until mem_resp, abort, or reset.
- A higher-priority request never preempts an active grant.

Optional Feature:
- Macro: PMEM_ARBITER_ROUND_ROBIN_EN.
- When defined:
  - A 1-bit last_grant register records the client of the last completed transaction, updated on mem_resp. Aborts do not update it. Reset value is I, so D wins the first tie.
  - On a tie in IDLE, the client that is not last_grant is granted.
  - Single-requester behaviour is unchanged.
- When undefined: fixed D-over-I priority and no last_grant register.

Test Plan:
- Reset with both clients idle: all outputs 0. Then d_pmem_read=1, d_pmem_address=16'h1230 → mem_read=1 and mem_address=16'h1230 one cycle later. mem_resp with mem_rdata=128'hDEAD_BEEF (zero-extended) → d_pmem_resp=1 and d_pmem_rdata=128'hDEAD_BEEF in the same cycle, then 1 cycle with mem_read=0.
- i_pmem_read (addr 16'h0040) and d_pmem_write (addr 16'h8000, wdata 128'h1) in the same cycle → D served first (mem_write=1, mem_address=16'h8000). I served after RELEASE+IDLE with i_pmem_resp only on its own completion. With PMEM_ARBITER_ROUND_ROBIN_EN, a second tie goes to I.
- I granted with a 5-cycle memory latency, d_pmem_read asserted mid-transaction → mem_address stays at the I address and d_pmem_resp stays 0 until I completes; D is granted afterwards.
- Abort: D granted, d_pmem_read deasserted before mem_resp → mem_read=0 that cycle, state returns to IDLE, no resp issued.
- reset asserted during SERVE_I → next cycle mem_read=0, i_pmem_resp=0, state IDLE. A pending d request is then granted normally after reset is released.
- Illegal i_pmem_read=i_pmem_write=1 → mem_write=1 and mem_read=0.
